// File: rtl/ddr4_ca_iod_dly_ctrl.sv
// DDR4 CA/BA IOD lane driver: one-cycle registered TX/OE/ODT path plus a
// request-driven FSM that steps a single lane's delay line tap by tap.

module ddr4_ca_iod_lane #(
  parameter int RATIO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RATIO-1:0] tx_in,
  input  logic [RATIO-1:0] oe_in,
  input  logic             odt_in,
  input  logic             oe_kill,
  input  logic             sel,
  input  logic             move_act,
  input  logic             load_act,
  input  logic             dir_act,
  output logic [RATIO-1:0] tx,
  output logic [RATIO-1:0] oe,
  output logic             odt,
  output logic             move,
  output logic             load,
  output logic             dir
);
  always_ff @(posedge clk) begin
    if (rst) begin
      tx  <= '0;
      oe  <= '0;
      odt <= 1'b0;
    end else begin
      tx  <= tx_in;
      oe  <= oe_kill ? '0 : oe_in;
      odt <= odt_in;
    end
  end

  assign move = sel & move_act;
  assign load = sel & load_act;
  assign dir  = sel & dir_act;
endmodule

module ddr4_ca_iod_dly_ctrl #(
  parameter int NUM_LANES      = 2,
  parameter int RATIO          = 4,
  parameter int TAP_W          = 8,
  parameter int TAP_MAX        = 255,
  parameter int RESET_TAP      = 1,
  parameter int MOVE_GAP       = 2,
  parameter int FREEZE_ON_MOVE = 0
) (
  input  logic                       FAB_CLK,
  input  logic                       TX_SYNC_RST,
  input  logic [NUM_LANES*RATIO-1:0] TX_DATA_IN,
  input  logic [NUM_LANES*RATIO-1:0] OE_DATA_IN,
  input  logic                       ODT_EN_IN,
  output logic [NUM_LANES*RATIO-1:0] TX_DATA,
  output logic [NUM_LANES*RATIO-1:0] OE_DATA,
  output logic [NUM_LANES-1:0]       ODT_EN,
  input  logic                       DLY_REQ_VALID,
  output logic                       DLY_REQ_READY,
  input  logic [3:0]                 DLY_REQ_LANE,
  input  logic [TAP_W-1:0]           DLY_REQ_TAP,
  input  logic                       DLY_REQ_LOAD,
  output logic                       DLY_DONE,
  output logic                       DLY_ERR,
  output logic [TAP_W-1:0]           DLY_CUR_TAP,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MOVE, GAP, DONE} state_t;

  typedef struct packed {
    logic [3:0]       lane;
    logic [TAP_W-1:0] tgt;
  } req_t;

  state_t                          state_q, state_d;
  req_t                            req_q;
  logic [NUM_LANES-1:0][TAP_W-1:0] tap_q;
  logic [TAP_W-1:0]                cur_q;
  logic                            err_q, dir_q;
  logic [2:0]                      gap_q;

  logic             accept, req_bad, up, oor, gap_last, motion_d;
  logic             move_act, load_act, dir_act;
  logic [LW-1:0]    req_idx, lane_idx;
  logic [TAP_W-1:0] cur, req_cur;
  logic [3:0]       lane_nx;
  logic [NUM_LANES-1:0] oe_kill;

  assign req_idx  = DLY_REQ_LANE[LW-1:0];
  assign lane_idx = req_q.lane[LW-1:0];
  assign req_cur  = tap_q[req_idx];
  assign cur      = tap_q[lane_idx];
  assign accept   = DLY_REQ_VALID && (state_q == IDLE);
  assign req_bad  = ({1'b0, DLY_REQ_LANE} >= 5'(NUM_LANES)) ||
                    ({1'b0, DLY_REQ_TAP} > (TAP_W+1)'(TAP_MAX));
  assign up       = req_q.tgt > cur;
  assign oor      = DELAY_LINE_OUT_OF_RANGE[lane_idx];
  assign gap_last = gap_q == 3'(MOVE_GAP - 1);

  always_comb begin
    state_d  = state_q;
    move_act = 1'b0;
    load_act = 1'b0;
    dir_act  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (req_bad)                    state_d = DONE;
        else if (DLY_REQ_LOAD)          state_d = LOAD;
        else if (DLY_REQ_TAP == req_cur) state_d = DONE;
        else                            state_d = MOVE;
      end
      LOAD: begin
        load_act = 1'b1;
        state_d  = (req_q.tgt == '0) ? DONE : MOVE;
      end
      MOVE: begin
        move_act = 1'b1;
        dir_act  = up;
        state_d  = GAP;
      end
      GAP: begin
        dir_act = dir_q;
        if (oor)           state_d = DONE;
        else if (gap_last) state_d = (cur == req_q.tgt) ? DONE : MOVE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // OE_DATA is registered, so the freeze keys off the state/lane of the next cycle.
  assign motion_d = (state_d == MOVE) || (state_d == GAP);
  assign lane_nx  = accept ? DLY_REQ_LANE : req_q.lane;

  always_comb begin
    oe_kill = '0;
    for (int l = 0; l < NUM_LANES; l++)
      oe_kill[l] = (FREEZE_ON_MOVE != 0) && motion_d && (lane_nx == 4'(l));
  end

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q <= IDLE;
      req_q   <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
      gap_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) tap_q[l] <= TAP_W'(RESET_TAP);
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          req_q.lane <= DLY_REQ_LANE;
          req_q.tgt  <= DLY_REQ_TAP;
          err_q      <= req_bad;
          if (!req_bad) cur_q <= req_cur;
        end
        LOAD: begin
          tap_q[lane_idx] <= '0;
          cur_q           <= '0;
        end
        MOVE: begin
          dir_q           <= up;
          gap_q           <= '0;
          tap_q[lane_idx] <= up ? cur + TAP_W'(1) : cur - TAP_W'(1);
          cur_q           <= up ? cur + TAP_W'(1) : cur - TAP_W'(1);
        end
        GAP: begin
          gap_q <= gap_q + 3'd1;
          if (oor) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DLY_REQ_READY = (state_q == IDLE) && !TX_SYNC_RST;
  assign DLY_DONE      = state_q == DONE;
  assign DLY_ERR       = err_q;
  assign DLY_CUR_TAP   = cur_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ddr4_ca_iod_lane #(.RATIO(RATIO)) u_lane (
      .clk      (FAB_CLK),
      .rst      (TX_SYNC_RST),
      .tx_in    (TX_DATA_IN[l*RATIO +: RATIO]),
      .oe_in    (OE_DATA_IN[l*RATIO +: RATIO]),
      .odt_in   (ODT_EN_IN),
      .oe_kill  (oe_kill[l]),
      .sel      (req_q.lane == 4'(l)),
      .move_act (move_act),
      .load_act (load_act),
      .dir_act  (dir_act),
      .tx       (TX_DATA[l*RATIO +: RATIO]),
      .oe       (OE_DATA[l*RATIO +: RATIO]),
      .odt      (ODT_EN[l]),
      .move     (DELAY_LINE_MOVE[l]),
      .load     (DELAY_LINE_LOAD[l]),
      .dir      (DELAY_LINE_DIRECTION[l])
    );
  end
endmodule

// File: tb/tb_ddr4_ca_iod_dly_ctrl.sv
// Bench for ddr4_ca_iod_dly_ctrl: directed vector table, random requests
// against a tap-arithmetic model, and a mid-move reset sequence.

module tb_ddr4_ca_iod_dly_ctrl;
  localparam int NL = 2, RT = 4, TMAX = 200, RTAP = 1, G = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   tx_in = '0, oe_in = '0, tx, oe;
  logic         odt_in = 1'b0;
  logic [1:0]   odt, mv, dir, dl, oor = '0;
  logic         vld = 1'b0, rdy, ld = 1'b0, done, err;
  logic [3:0]   lane = '0;
  logic [7:0]   tap = '0, cur;

  logic [7:0]   ptx = '0, poe = '0;
  logic         podt = 1'b0;
  int           checks = 0, errors = 0;
  int           mtap[2];

  always #5 clk = ~clk;

  ddr4_ca_iod_dly_ctrl #(
    .NUM_LANES(NL), .RATIO(RT), .TAP_W(8), .TAP_MAX(TMAX), .RESET_TAP(RTAP),
    .MOVE_GAP(G), .FREEZE_ON_MOVE(1)
  ) dut (
    .FAB_CLK(clk), .TX_SYNC_RST(rst),
    .TX_DATA_IN(tx_in), .OE_DATA_IN(oe_in), .ODT_EN_IN(odt_in),
    .TX_DATA(tx), .OE_DATA(oe), .ODT_EN(odt),
    .DLY_REQ_VALID(vld), .DLY_REQ_READY(rdy), .DLY_REQ_LANE(lane),
    .DLY_REQ_TAP(tap), .DLY_REQ_LOAD(ld),
    .DLY_DONE(done), .DLY_ERR(err), .DLY_CUR_TAP(cur),
    .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(dl),
    .DELAY_LINE_OUT_OF_RANGE(oor)
  );

  typedef struct {
    int lane; int tap; bit load; int oor_c;
    bit err; int done; int moves; bit dir; int cur;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: sample data path at the falling edge, then drive fresh inputs.
  task automatic tick(input int frz, input bit zero);
    logic [7:0] etx, eoe;
    logic [1:0] eodt;
    @(negedge clk);
    etx  = zero ? 8'h0 : ptx;
    eoe  = zero ? 8'h0 : poe;
    eodt = zero ? 2'b00 : {2{podt}};
    if (!zero && frz >= 0) eoe[frz*RT +: RT] = '0;
    chk("tx_data", tx, etx);
    chk("oe_data", oe, eoe);
    chk("odt_en", odt, eodt);
    tx_in  = 8'($urandom);
    oe_in  = 8'($urandom);
    odt_in = 1'($urandom);
    ptx = tx_in; poe = oe_in; podt = odt_in;
  endtask

  task automatic run_req(input int lane_i, input int tap_i, input bit load_i,
                         input int oor_c, input bit e_err, input int e_done,
                         input int e_moves, input bit e_dir, input int e_cur,
                         input bit noise);
    int mstart, wend, d, nmv, nld, sched_bad, dir_bad, stray, cur_at, c;
    bit seen, in_win, e_ld;
    logic [1:0] own;
    own    = (lane_i < NL) ? 2'(1 << lane_i) : 2'b00;
    e_ld   = load_i && (lane_i < NL) && (tap_i <= TMAX);
    mstart = load_i ? 2 : 1;
    wend   = (e_moves > 0) ? e_done - 1 : -1;
    d = -1; nmv = 0; nld = 0; sched_bad = 0; dir_bad = 0; stray = 0; cur_at = -1;
    seen = 0;
    tick(-1, 0);
    chk("ready_idle", rdy, 1);
    vld = 1; lane = 4'(lane_i); tap = 8'(tap_i); ld = load_i;
    @(posedge clk);
    #1;
    vld = noise;
    c = 1;
    while (!seen && c <= e_done + 20) begin
      in_win = (c >= mstart) && (c <= wend);
      tick(in_win ? lane_i : -1, 0);
      if ((mv & own) != 0) begin
        if (c != mstart + nmv * (1 + G)) sched_bad++;
        nmv++;
      end
      if ((dl & own) != 0) begin
        if (c != 1) sched_bad++;
        nld++;
      end
      if (((mv | dl | dir) & ~own) != 0) stray++;
      if (own != 0 && (((dir & own) != 0) != (in_win ? e_dir : 1'b0))) dir_bad++;
      oor = '0;
      if (c == oor_c && lane_i < NL) oor[lane_i] = 1'b1;
      if (done) begin
        seen = 1; d = c; cur_at = int'(cur);
        chk("err_at_done", err, e_err);
        vld = 0;
      end else begin
        if (rdy) stray++;
        if (noise) begin
          lane = 4'($urandom); tap = 8'($urandom); ld = 1'($urandom);
        end
      end
      c++;
    end
    oor = '0; vld = 0;
    chk("done_cycle", d, e_done);
    chk("move_count", nmv, e_moves);
    chk("load_count", nld, int'(e_ld));
    chk("pulse_sched", sched_bad, 0);
    chk("direction", dir_bad, 0);
    chk("stray_ctrl", stray, 0);
    if (e_cur >= 0) chk("cur_tap", cur_at, e_cur);
    tick(-1, 0);
    chk("done_one_cycle", done, 0);
    chk("ready_after", rdy, 1);
    chk("err_hold", err, e_err);
  endtask

  initial begin
    int l, t, r, start, mvs;
    bit ldr, bad;
    //            lane tap  ld oor err done moves dir cur
    tbl[0]  = '{1,   3,  1, 0,  0,  11,    3,  1,  3};
    tbl[1]  = '{1,   1,  0, 0,  0,   7,    2,  0,  1};
    tbl[2]  = '{1,   1,  0, 0,  0,   1,    0,  0,  1};
    tbl[3]  = '{2,   5,  0, 0,  1,   1,    0,  0, -1};
    tbl[4]  = '{0, 201,  0, 0,  1,   1,    0,  0, -1};
    tbl[5]  = '{0,   1,  0, 0,  0,   1,    0,  0,  1};
    tbl[6]  = '{1,   1,  0, 0,  0,   1,    0,  0,  1};
    tbl[7]  = '{0,   6,  0, 2,  1,   3,    1,  1,  2};
    tbl[8]  = '{0, 200,  1, 0,  0, 602,  200,  1, 200};
    tbl[9]  = '{0,   0,  1, 0,  0,   2,    0,  0,  0};
    tbl[10] = '{0,   0,  0, 0,  0,   1,    0,  0,  0};

    // Reset state
    repeat (3) @(posedge clk);
    tick(-1, 1);
    chk("rst_ready", rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur", cur, 0);
    chk("rst_ctrl", {mv, dir, dl}, 0);
    rst = 0;
    tick(-1, 0);
    chk("ready_after_rst", rdy, 1);

    mtap[0] = RTAP; mtap[1] = RTAP;
    foreach (tbl[i]) begin
      run_req(tbl[i].lane, tbl[i].tap, tbl[i].load, tbl[i].oor_c, tbl[i].err,
              tbl[i].done, tbl[i].moves, tbl[i].dir, tbl[i].cur, 0);
      if (tbl[i].cur >= 0) mtap[tbl[i].lane] = tbl[i].cur;
    end

    // Random requests against the tap model
    for (int n = 0; n < 40; n++) begin
      l   = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
      ldr = ($urandom_range(0, 3) == 0);
      r   = int'($urandom_range(0, 9));
      if (r == 0)                t = 201 + int'($urandom_range(0, 54));
      else if (r == 1 && l < NL) t = mtap[l];
      else                       t = int'($urandom_range(0, 12));
      bad = (l >= NL) || (t > TMAX);
      if (bad) begin
        run_req(l, t, ldr, 0, 1, 1, 0, 0, -1, 1);
      end else begin
        start = ldr ? 0 : mtap[l];
        mvs   = (t > start) ? t - start : start - t;
        run_req(l, t, ldr, 0, 0, int'(ldr) + mvs * (1 + G) + 1, mvs, t > start, t, 1);
        mtap[l] = t;
      end
    end

    // Reset during the second GAP of a lane-1 move
    begin
      int dcnt;
      dcnt = 0;
      tick(-1, 0);
      vld = 1; lane = 4'd1; tap = 8'd5; ld = 1;
      @(posedge clk);
      #1;
      vld = 0;
      for (int c = 1; c <= 12; c++) begin
        tick((c >= 2 && c <= 6) ? 1 : -1, c == 7);
        if (done) dcnt++;
        if (c == 6) rst = 1;
        if (c == 7) begin
          chk("mid_rst_ready", rdy, 0);
          chk("mid_rst_ctrl", {mv, dir, dl}, 0);
          chk("mid_rst_cur", cur, 0);
          rst = 0;
        end
        if (c == 8) chk("ready_after_release", rdy, 1);
      end
      chk("no_done_on_abort", dcnt, 0);
    end
    run_req(0, RTAP, 0, 0, 0, 1, 0, 0, RTAP, 0);
    run_req(1, RTAP, 0, 0, 0, 1, 0, 0, RTAP, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr4_ca_iod_dly_ctrl.md
DDR4_CA_IOD_DLY_CTRL -- requirements
Module: ddr4_ca_iod_dly_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 2, number of CA/BA IOD lanes driven (1..16).
REQ-002 Parameter RATIO, default 4, TX/OE bits per lane per FAB_CLK cycle.
REQ-003 Parameter TAP_W, default 8, width of the delay tap counter.
REQ-004 Parameter TAP_MAX, default 255, highest legal tap value.
REQ-005 Parameter RESET_TAP, default 1, tap value assumed after reset (matches the IOD TX_DELAY_VAL).
REQ-006 Parameter MOVE_GAP, default 2, idle cycles after each MOVE pulse (1..7).
REQ-007 Parameter FREEZE_ON_MOVE, default 0, when 1 the lane being moved has OE forced low.
REQ-008 FAB_CLK  in  1  sole clock; all logic is on its rising edge.
REQ-009 TX_SYNC_RST  in  1  reset, synchronous to FAB_CLK, active-high.
REQ-010 TX_DATA_IN  in  NUM_LANES*RATIO  fabric TX data, lane L at bits [L*RATIO +: RATIO].
REQ-011 OE_DATA_IN  in  NUM_LANES*RATIO  fabric OE data, same packing.
REQ-012 ODT_EN_IN  in  1  ODT enable broadcast.
REQ-013 TX_DATA  out  NUM_LANES*RATIO  registered data to the IODs.
REQ-014 OE_DATA  out  NUM_LANES*RATIO  registered OE to the IODs.
REQ-015 ODT_EN  out  NUM_LANES  registered per-lane ODT enable.
REQ-016 DLY_REQ_VALID / DLY_REQ_READY  in / out  1 / 1  delay request handshake.
REQ-017 DLY_REQ_LANE  in  4  target lane index.
REQ-018 DLY_REQ_TAP  in  TAP_W  target tap value.
REQ-019 DLY_REQ_LOAD  in  1  1 = reset the delay line to tap 0 before moving.
REQ-020 DLY_DONE  out  1  one-cycle completion pulse; DLY_ERR  out  1  error flag, valid with DLY_DONE.
REQ-021 DLY_CUR_TAP  out  TAP_W  tracked tap of the most recently requested lane.
REQ-022 DELAY_LINE_MOVE / DELAY_LINE_DIRECTION / DELAY_LINE_LOAD  out  NUM_LANES each  per-lane IOD delay controls.
REQ-023 DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flag.

Function
REQ-024 TX_DATA, OE_DATA, ODT_EN SHALL be the inputs registered once (latency 1 cycle); ODT_EN_IN fans out to all lanes.
REQ-025 With FREEZE_ON_MOVE=1, OE_DATA for the active lane SHALL be 0 in every cycle the FSM is in MOVE or GAP.
REQ-026 FSM states SHALL be IDLE, LOAD, MOVE, GAP, DONE; DLY_REQ_READY=1 only in IDLE.
REQ-027 IDLE: on VALID&READY capture lane/tap/load; lane>=NUM_LANES or tap>TAP_MAX -> DONE with ERR=1, no pulses; else load=1 -> LOAD; else tap==cur -> DONE; else MOVE.
REQ-028 LOAD: DELAY_LINE_LOAD[lane]=1 for exactly one cycle, tap[lane]<=0; next state is DONE if target is 0, else MOVE.
REQ-029 MOVE: DELAY_LINE_MOVE[lane]=1 for exactly one cycle; tap[lane] increments if target>cur, else decrements; next state is GAP.
REQ-030 DELAY_LINE_DIRECTION[lane] SHALL be 1 for increment and 0 for decrement, valid from the MOVE cycle through the end of the GAP that follows it.
REQ-031 GAP lasts MOVE_GAP cycles; DELAY_LINE_OUT_OF_RANGE[lane]=1 in any GAP cycle -> DONE with ERR=1; otherwise, at the end of GAP, -> DONE if tap==target, else MOVE.
REQ-032 DONE: DLY_DONE=1 for one cycle, then IDLE; DLY_ERR holds its value until the next accepted request.
REQ-033 Tap counters SHALL never wrap: a move past 0 or TAP_MAX is impossible by construction, because legal targets are bounded.
REQ-034 Only the captured lane's MOVE, LOAD and DIRECTION bits SHALL ever be nonzero; all other lanes stay 0.
REQ-035 VALID asserted outside IDLE SHALL be ignored; the requester holds it until READY.

Reset
REQ-036 TX_SYNC_RST=1 SHALL, on the next edge, put the FSM in IDLE, clear all outputs to 0, set every tap[] to RESET_TAP, and clear DLY_ERR.
REQ-037 Reset mid-operation SHALL abort with no DLY_DONE pulse; DLY_REQ_READY=0 while reset is high, and 1 from the first cycle after release.

Verification
REQ-038 Reset release, then request lane 1, LOAD=1, TAP=3, MOVE_GAP=2, accepted at cycle 0 -> LOAD[1] at 1; MOVE[1] at 2, 5, 8 with DIRECTION[1]=1; DLY_DONE at 11; DLY_CUR_TAP=3; ERR=0.
REQ-039 From tap 3, request lane 1, LOAD=0, TAP=1 -> two MOVE pulses with DIRECTION=0, DLY_DONE, tap=1; request TAP=1 again -> DLY_DONE the cycle after acceptance, no MOVE.
REQ-040 Request lane=NUM_LANES (2), or TAP=TAP_MAX+1 when TAP_MAX<255 -> DLY_DONE with ERR=1, zero MOVE/LOAD pulses, taps unchanged.
REQ-041 OUT_OF_RANGE[0] forced high in the first GAP cycle of a 5-step move -> exactly one MOVE pulse, DLY_DONE with ERR=1.
REQ-042 TX_SYNC_RST pulsed during the second GAP -> no DLY_DONE, all taps = RESET_TAP, READY=1 the cycle after release.
REQ-043 Random TX_DATA_IN/OE_DATA_IN, FREEZE_ON_MOVE=1, move on lane 0 -> outputs equal inputs delayed one cycle, except lane 0 OE=0 during MOVE/GAP.
